// File: rtl/itlb_ptw.sv
// -----------------------------------------------------------------------------
// itlb_ptw -- Sv32 page-table walker serving the instruction TLB.
//
// Accepts a one-cycle walk request from the I-TLB, reads up to two PTEs over
// an AXI read channel and returns the leaf PTE (or a fault) as a one-cycle
// response pulse. Bare mode (SATP_MODE=0) returns an identity mapping with
// no memory traffic.
//
// Ports:
//   CLK, RST                 clock (rising edge), asynchronous active-low reset
//   REQ_VALID, REQ_VADDR     walk request pulse and virtual address
//   FLUSH                    cancels the response of a walk in flight
//   SATP_MODE, SATP_PPN      translation mode (0 bare, 1 Sv32) and root PPN
//   RESP_VALID, RESP_DATA    response pulse and leaf PTE {PPN, flags}
//   FAULT, FAULT_TYPE        fault qualifier; 01 page fault, 10 access fault
//   BUSY                     walk in progress
//   M_AR*, M_R*              AXI read address / read data channels
//
// Build option:
//   ITLB_PTW_SUPERPAGE_EN    when defined, aligned level-1 leaves are returned
//                            as 4 MiB superpages; otherwise they page-fault.
// -----------------------------------------------------------------------------
module itlb_ptw #(
  parameter int ADDR_WIDTH        = 32,
  parameter int DATA_WIDTH        = 32,
  parameter int PAGE_OFFSET_WIDTH = 12,
  parameter int VPN_LEN           = 10,
  parameter int PPN_LEN           = 22
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ_VALID,
  input  logic [ADDR_WIDTH-1:0] REQ_VADDR,
  input  logic                  FLUSH,
  input  logic                  SATP_MODE,
  input  logic [PPN_LEN-1:0]    SATP_PPN,
  output logic                  RESP_VALID,
  output logic [DATA_WIDTH-1:0] RESP_DATA,
  output logic                  FAULT,
  output logic [1:0]            FAULT_TYPE,
  output logic                  BUSY,
  output logic                  M_ARVALID,
  input  logic                  M_ARREADY,
  output logic [ADDR_WIDTH-1:0] M_ARADDR,
  input  logic                  M_RVALID,
  output logic                  M_RREADY,
  input  logic [DATA_WIDTH-1:0] M_RDATA,
  input  logic [1:0]            M_RRESP
);

  localparam int FLAG_W    = DATA_WIDTH - PPN_LEN;
  localparam int VPN0_LSB  = PAGE_OFFSET_WIDTH;
  localparam int VPN1_LSB  = PAGE_OFFSET_WIDTH + VPN_LEN;
  localparam int VA_PN_W   = ADDR_WIDTH - PAGE_OFFSET_WIDTH;
  // PPN bits that survive truncation of {ppn, vpn, 2'b00} to ADDR_WIDTH
  localparam int TBL_PPN_W = ADDR_WIDTH - VPN_LEN - 2;

  localparam logic [FLAG_W-1:0] BARE_FLAGS = 'h0CF;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_AR1  = 3'd1;
  localparam logic [2:0] S_R1   = 3'd2;
  localparam logic [2:0] S_AR0  = 3'd3;
  localparam logic [2:0] S_R0   = 3'd4;
  localparam logic [2:0] S_RESP = 3'd5;

  localparam logic [1:0] FT_NONE   = 2'b00;
  localparam logic [1:0] FT_PAGE   = 2'b01;
  localparam logic [1:0] FT_ACCESS = 2'b10;

  logic [2:0]            state_q,      state_d;
  logic                  cancel_q,     cancel_d;
  logic [VPN_LEN-1:0]    vpn0_q,       vpn0_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0] resp_data_q,  resp_data_d;
  logic                  fault_q,      fault_d;
  logic [1:0]            fault_type_q, fault_type_d;
  logic                  busy_q,       busy_d;
  logic                  arvalid_q,    arvalid_d;
  logic [ADDR_WIDTH-1:0] araddr_q,     araddr_d;
  logic                  rready_q,     rready_d;

  logic                  cancel_eff;
  logic                  go_resp;
  logic [1:0]            resp_ft;
  logic [DATA_WIDTH-1:0] resp_pte;
  logic                  pte_v, pte_r, pte_w, pte_x;
  logic                  pte_bad, pte_leaf;

  // Page-offset bits and the PPN bits above the truncated PTE address
  // play no part in the walk.
  logic unused_bits;
  assign unused_bits = ^{REQ_VADDR[PAGE_OFFSET_WIDTH-1:0], SATP_PPN[PPN_LEN-1:TBL_PPN_W]};

  assign pte_v    = M_RDATA[0];
  assign pte_r    = M_RDATA[1];
  assign pte_w    = M_RDATA[2];
  assign pte_x    = M_RDATA[3];
  assign pte_bad  = !pte_v || (!pte_r && pte_w);
  assign pte_leaf = pte_r || pte_x;

  // A FLUSH seen this cycle counts immediately so the beat arriving in the
  // same cycle is already treated as cancelled.
  assign cancel_eff = (state_q != S_IDLE) && (cancel_q || FLUSH);

  always_comb begin
    state_d      = state_q;
    vpn0_d       = vpn0_q;
    araddr_d     = araddr_q;
    resp_data_d  = resp_data_q;
    fault_d      = fault_q;
    fault_type_d = fault_type_q;
    go_resp      = 1'b0;
    resp_ft      = FT_NONE;
    resp_pte     = '0;

    case (state_q)
      S_IDLE: begin
        if (REQ_VALID) begin
          vpn0_d = REQ_VADDR[VPN1_LSB-1:VPN0_LSB];
          if (!SATP_MODE) begin
            go_resp  = 1'b1;
            resp_pte = {{(PPN_LEN-VA_PN_W){1'b0}}, REQ_VADDR[ADDR_WIDTH-1:VPN0_LSB], BARE_FLAGS};
          end else begin
            state_d  = S_AR1;
            araddr_d = {SATP_PPN[TBL_PPN_W-1:0], REQ_VADDR[ADDR_WIDTH-1:VPN1_LSB], 2'b00};
          end
        end
      end
      S_AR1: if (M_ARREADY) state_d = S_R1;
      S_R1: begin
        if (M_RVALID) begin
          if (M_RRESP != 2'b00) begin
            go_resp = 1'b1;
            resp_ft = FT_ACCESS;
          end else if (pte_bad) begin
            go_resp = 1'b1;
            resp_ft = FT_PAGE;
          end else if (pte_leaf) begin
            go_resp = 1'b1;
`ifdef ITLB_PTW_SUPERPAGE_EN
            if (M_RDATA[FLAG_W+VPN_LEN-1:FLAG_W] == '0)
              resp_pte = {M_RDATA[DATA_WIDTH-1:FLAG_W+VPN_LEN], vpn0_q, M_RDATA[FLAG_W-1:0]};
            else
              resp_ft = FT_PAGE;
`else
            resp_ft = FT_PAGE;
`endif
          end else if (cancel_eff) begin
            state_d = S_IDLE;
          end else begin
            state_d  = S_AR0;
            araddr_d = {M_RDATA[FLAG_W +: TBL_PPN_W], vpn0_q, 2'b00};
          end
        end
      end
      S_AR0: if (M_ARREADY) state_d = S_R0;
      S_R0: begin
        if (M_RVALID) begin
          go_resp = 1'b1;
          if (M_RRESP != 2'b00)  resp_ft = FT_ACCESS;
          else if (pte_bad)      resp_ft = FT_PAGE;
          else if (pte_leaf)     resp_pte = M_RDATA;
          else                   resp_ft = FT_PAGE;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Every terminating beat funnels through here so a cancelled walk
    // drops straight to IDLE without touching the response registers.
    if (go_resp) begin
      if (cancel_eff) begin
        state_d = S_IDLE;
      end else begin
        state_d      = S_RESP;
        fault_d      = (resp_ft != FT_NONE);
        fault_type_d = resp_ft;
        resp_data_d  = (resp_ft != FT_NONE) ? '0 : resp_pte;
      end
    end

    cancel_d     = (state_d != S_IDLE) && cancel_eff;
    resp_valid_d = (state_d == S_RESP);
    busy_d       = (state_d != S_IDLE);
    arvalid_d    = (state_d == S_AR1) || (state_d == S_AR0);
    rready_d     = (state_d == S_IDLE) || (state_d == S_R1) || (state_d == S_R0);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= S_IDLE;
      cancel_q     <= 1'b0;
      vpn0_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      fault_q      <= 1'b0;
      fault_type_q <= FT_NONE;
      busy_q       <= 1'b0;
      arvalid_q    <= 1'b0;
      araddr_q     <= '0;
      rready_q     <= 1'b1;
    end else begin
      state_q      <= state_d;
      cancel_q     <= cancel_d;
      vpn0_q       <= vpn0_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      fault_q      <= fault_d;
      fault_type_q <= fault_type_d;
      busy_q       <= busy_d;
      arvalid_q    <= arvalid_d;
      araddr_q     <= araddr_d;
      rready_q     <= rready_d;
    end
  end

  assign RESP_VALID = resp_valid_q;
  assign RESP_DATA  = resp_data_q;
  assign FAULT      = fault_q;
  assign FAULT_TYPE = fault_type_q;
  assign BUSY       = busy_q;
  assign M_ARVALID  = arvalid_q;
  assign M_ARADDR   = araddr_q;
  assign M_RREADY   = rready_q;

endmodule

// File: tb/tb_itlb_ptw.sv
// -----------------------------------------------------------------------------
// tb_itlb_ptw -- self-checking bench for itlb_ptw.
//
// A behavioural model computes the expected PTE addresses and response of a
// walk from the translation rules using plain arithmetic; an AXI responder
// serves the chosen PTEs with random handshake delays. Directed cases cover
// bare mode, a two-level walk, access fault, level-1 leaf, flush and reset.
// Define ITLB_PTW_SUPERPAGE_EN for both bench and design to test superpages.
// -----------------------------------------------------------------------------
module tb_itlb_ptw;

  logic        CLK = 1'b0;
  logic        RST;
  logic        REQ_VALID;
  logic [31:0] REQ_VADDR;
  logic        FLUSH;
  logic        SATP_MODE;
  logic [21:0] SATP_PPN;
  logic        RESP_VALID;
  logic [31:0] RESP_DATA;
  logic        FAULT;
  logic [1:0]  FAULT_TYPE;
  logic        BUSY;
  logic        M_ARVALID;
  logic        M_ARREADY;
  logic [31:0] M_ARADDR;
  logic        M_RVALID;
  logic        M_RREADY;
  logic [31:0] M_RDATA;
  logic [1:0]  M_RRESP;

  itlb_ptw #(
    .ADDR_WIDTH       (32),
    .DATA_WIDTH       (32),
    .PAGE_OFFSET_WIDTH(12),
    .VPN_LEN          (10),
    .PPN_LEN          (22)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .REQ_VALID (REQ_VALID),
    .REQ_VADDR (REQ_VADDR),
    .FLUSH     (FLUSH),
    .SATP_MODE (SATP_MODE),
    .SATP_PPN  (SATP_PPN),
    .RESP_VALID(RESP_VALID),
    .RESP_DATA (RESP_DATA),
    .FAULT     (FAULT),
    .FAULT_TYPE(FAULT_TYPE),
    .BUSY      (BUSY),
    .M_ARVALID (M_ARVALID),
    .M_ARREADY (M_ARREADY),
    .M_ARADDR  (M_ARADDR),
    .M_RVALID  (M_RVALID),
    .M_RREADY  (M_RREADY),
    .M_RDATA   (M_RDATA),
    .M_RRESP   (M_RRESP)
  );

  always #5 CLK = ~CLK;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [1:0]  n_ar;
    logic [31:0] a0;
    logic [31:0] a1;
    logic        fault;
    logic [1:0]  ft;
    logic [31:0] data;
  } exp_t;

  function automatic bit bit_of(input logic [31:0] p, input int unsigned k);
    return ((p / (32'd1 << k)) % 2) == 1;
  endfunction

  function automatic bit pte_ok(input logic [31:0] p);
    return bit_of(p, 0) && !(!bit_of(p, 1) && bit_of(p, 2));
  endfunction

  function automatic bit pte_is_leaf(input logic [31:0] p);
    return bit_of(p, 1) || bit_of(p, 3);
  endfunction

  // Reference walk: expected PTE addresses and final response.
  function automatic exp_t model(input logic mode, input logic [31:0] va, input logic [21:0] ppn,
                                 input logic [31:0] p1, input logic [1:0] rr1,
                                 input logic [31:0] p0, input logic [1:0] rr0);
    exp_t        e;
    logic [63:0] a;
    e = '0;
    if (!mode) begin
      e.data = (va / 4096) * 1024 + 32'h0CF;
      return e;
    end
    a      = 64'(ppn) * 4096 + 64'(va / 32'h0040_0000) * 4;
    e.n_ar = 2'd1;
    e.a0   = a[31:0];
    if (rr1 != 2'b00) begin e.fault = 1'b1; e.ft = 2'b10; return e; end
    if (!pte_ok(p1))  begin e.fault = 1'b1; e.ft = 2'b01; return e; end
    if (pte_is_leaf(p1)) begin
`ifdef ITLB_PTW_SUPERPAGE_EN
      if (((p1 / 1024) % 1024) == 0) begin
        e.data = (p1 / 32'h0010_0000) * 32'h0010_0000 + ((va / 4096) % 1024) * 1024 + p1 % 1024;
        return e;
      end
`endif
      e.fault = 1'b1; e.ft = 2'b01;
      return e;
    end
    a      = 64'(p1 / 1024) * 4096 + 64'((va / 4096) % 1024) * 4;
    e.n_ar = 2'd2;
    e.a1   = a[31:0];
    if (rr0 != 2'b00)                         begin e.fault = 1'b1; e.ft = 2'b10; return e; end
    if (!pte_ok(p0) || !pte_is_leaf(p0))      begin e.fault = 1'b1; e.ft = 2'b01; return e; end
    e.data = p0;
    return e;
  endfunction

  function automatic logic [31:0] rand_pte();
    logic [31:0] p;
    p = $urandom;
    case ($urandom_range(0, 4))
      0: p[0] = 1'b0;
      1: begin p[0] = 1'b1; p[1] = 1'b0; p[2] = 1'b1; end
      2: begin p[0] = 1'b1; p[1] = 1'b0; p[2] = 1'b0; p[3] = 1'b0; end
      3: begin p[0] = 1'b1; p[1] = 1'b1; end
      default: begin p[0] = 1'b1; p[3] = 1'b1; p[2] = p[1]; p[19:10] = '0; end
    endcase
    return p;
  endfunction

  function automatic logic [1:0] rand_resp();
    logic [1:0] r;
    r = '0;
    if ($urandom_range(0, 7) == 0) r = 2'($urandom_range(1, 3));
    return r;
  endfunction

  // One walk; inputs change on the falling edge, outputs are sampled there.
  task automatic run_walk(input string name, input logic mode, input logic [31:0] va,
                          input logic [21:0] ppn, input logic [31:0] p1, input logic [1:0] rr1,
                          input logic [31:0] p0, input logic [1:0] rr0);
    exp_t        e;
    int unsigned n_ar;
    int unsigned cyc;
    int unsigned r_dly;
    bit          r_pend;
    bit          done;
    e      = model(mode, va, ppn, p1, rr1, p0, rr0);
    n_ar   = 0;
    cyc    = 1;
    r_dly  = 0;
    r_pend = 1'b0;
    done   = 1'b0;
    @(negedge CLK);
    REQ_VALID = 1'b1;
    REQ_VADDR = va;
    SATP_MODE = mode;
    SATP_PPN  = ppn;
    @(negedge CLK);
    REQ_VADDR = $urandom;
    while (!done && cyc <= 300) begin
      REQ_VALID = 1'b0;
      M_ARREADY = 1'b0;
      M_RVALID  = 1'b0;
      if (RESP_VALID) begin
        if (!mode) check({name, ":latency"}, cyc, 1);
        check({name, ":n_ar"},       n_ar, 32'(e.n_ar));
        check({name, ":data"},       RESP_DATA, e.data);
        check({name, ":fault"},      FAULT, 32'(e.fault));
        check({name, ":fault_type"}, FAULT_TYPE, 32'(e.ft));
        done = 1'b1;
      end else begin
        if (M_ARVALID) begin
          if (n_ar >= e.n_ar) begin
            check({name, ":unexpected_ar"}, M_ARADDR, 32'hFFFF_FFFF);
            done = 1'b1;
          end else begin
            check({name, ":araddr"}, M_ARADDR, (n_ar == 0) ? e.a0 : e.a1);
            if ($urandom_range(0, 2) != 0) begin
              M_ARREADY = 1'b1;
              n_ar++;
              r_pend = 1'b1;
              r_dly  = $urandom_range(0, 2);
            end
          end
        end else if (r_pend) begin
          if (r_dly == 0) begin
            check({name, ":rready"}, M_RREADY, 1);
            M_RVALID = 1'b1;
            M_RDATA  = (n_ar == 1) ? p1 : p0;
            M_RRESP  = (n_ar == 1) ? rr1 : rr0;
            r_pend   = 1'b0;
          end else begin
            r_dly--;
          end
        end else if (!BUSY) begin
          check({name, ":no_response"}, 0, 1);
          done = 1'b1;
        end
        // Requests while a walk is running must be ignored.
        if (BUSY && $urandom_range(0, 3) == 0) begin
          REQ_VALID = 1'b1;
          REQ_VADDR = $urandom;
        end
      end
      if (!done) begin
        @(negedge CLK);
        cyc++;
      end
    end
    if (!done) check({name, ":timeout"}, 0, 1);
    REQ_VALID = 1'b0;
    M_ARREADY = 1'b0;
    M_RVALID  = 1'b0;
    @(negedge CLK);
    check({name, ":pulse_len"}, RESP_VALID, 0);
    check({name, ":idle"},      BUSY, 0);
    check({name, ":data_hold"}, RESP_DATA, e.data);
    // A stray beat in IDLE must be drained silently.
    M_RVALID = 1'b1;
    M_RDATA  = $urandom;
    M_RRESP  = 2'b00;
    @(negedge CLK);
    M_RVALID = 1'b0;
    check({name, ":stray_busy"}, BUSY, 0);
    check({name, ":stray_resp"}, RESP_VALID, 0);
  endtask

  task automatic flush_test();
    @(negedge CLK);
    SATP_MODE = 1'b1;
    SATP_PPN  = 22'h00080;
    REQ_VADDR = 32'h0040_1234;
    REQ_VALID = 1'b1;
    @(negedge CLK);
    REQ_VALID = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("flush:arvalid_hold", M_ARVALID, 1);
      check("flush:araddr_hold",  M_ARADDR, 32'h0008_0004);
      @(negedge CLK);
    end
    M_ARREADY = 1'b1;
    @(negedge CLK);
    M_ARREADY = 1'b0;
    check("flush:busy_r1",    BUSY, 1);
    check("flush:arvalid_r1", M_ARVALID, 0);
    FLUSH = 1'b1;
    @(negedge CLK);
    FLUSH    = 1'b0;
    check("flush:rready", M_RREADY, 1);
    M_RVALID = 1'b1;
    M_RDATA  = 32'h0002_0401;
    M_RRESP  = 2'b00;
    @(negedge CLK);
    M_RVALID = 1'b0;
    check("flush:busy_after_beat", BUSY, 0);
    for (int i = 0; i < 3; i++) begin
      check("flush:no_ar0",  M_ARVALID, 0);
      check("flush:no_resp", RESP_VALID, 0);
      @(negedge CLK);
    end
  endtask

  task automatic reset_test();
    @(negedge CLK);
    SATP_MODE = 1'b1;
    SATP_PPN  = 22'h00080;
    REQ_VADDR = 32'h0040_1234;
    REQ_VALID = 1'b1;
    @(negedge CLK);
    REQ_VALID = 1'b0;
    check("rst:ar1", M_ARADDR, 32'h0008_0004);
    M_ARREADY = 1'b1;
    @(negedge CLK);
    M_ARREADY = 1'b0;
    M_RVALID  = 1'b1;
    M_RDATA   = 32'h0002_0401;
    M_RRESP   = 2'b00;
    @(negedge CLK);
    M_RVALID = 1'b0;
    check("rst:ar0_valid", M_ARVALID, 1);
    check("rst:ar0_addr",  M_ARADDR, 32'h0008_1004);
    #2;
    RST = 1'b0;
    #1;
    check("rst:arvalid", M_ARVALID, 0);
    check("rst:busy",    BUSY, 0);
    check("rst:rready",  M_RREADY, 1);
    check("rst:araddr",  M_ARADDR, 0);
    check("rst:data",    RESP_DATA, 0);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check("rst:stray_rready", M_RREADY, 1);
    M_RVALID = 1'b1;
    M_RDATA  = 32'h1234_50CF;
    @(negedge CLK);
    M_RVALID = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("rst:stray_resp", RESP_VALID, 0);
      check("rst:stray_busy", BUSY, 0);
      @(negedge CLK);
    end
  endtask

  initial begin
    logic        md;
    logic [31:0] va;
    logic [21:0] ppn;
    logic [31:0] p1;
    logic [31:0] p0;
    logic [1:0]  r1;
    logic [1:0]  r0;
    RST       = 1'b0;
    REQ_VALID = 1'b0;
    REQ_VADDR = '0;
    FLUSH     = 1'b0;
    SATP_MODE = 1'b0;
    SATP_PPN  = '0;
    M_ARREADY = 1'b0;
    M_RVALID  = 1'b0;
    M_RDATA   = '0;
    M_RRESP   = '0;
    repeat (3) @(negedge CLK);
    check("reset:resp_valid", RESP_VALID, 0);
    check("reset:resp_data",  RESP_DATA, 0);
    check("reset:fault",      FAULT, 0);
    check("reset:fault_type", FAULT_TYPE, 0);
    check("reset:busy",       BUSY, 0);
    check("reset:arvalid",    M_ARVALID, 0);
    check("reset:araddr",     M_ARADDR, 0);
    check("reset:rready",     M_RREADY, 1);
    RST = 1'b1;

    run_walk("bare",     1'b0, 32'h8000_1ABC, 22'h0, 32'h0, 2'b00, 32'h0, 2'b00);
    check("bare:const", RESP_DATA, 32'h2000_04CF);
    run_walk("sv32",     1'b1, 32'h0040_1234, 22'h00080, 32'h0002_0401, 2'b00, 32'h1234_50CF, 2'b00);
    check("sv32:const", RESP_DATA, 32'h1234_50CF);
    run_walk("l1_err",   1'b1, 32'h0040_1234, 22'h00080, 32'h0002_0401, 2'b10, 32'h1234_50CF, 2'b00);
    run_walk("l1_leaf",  1'b1, 32'h0040_1234, 22'h00080, 32'h2000_000F, 2'b00, 32'h1234_50CF, 2'b00);
    run_walk("l0_err",   1'b1, 32'h0040_1234, 22'h00080, 32'h0002_0401, 2'b00, 32'h1234_50CF, 2'b01);
    run_walk("l0_table", 1'b1, 32'h0040_1234, 22'h00080, 32'h0002_0401, 2'b00, 32'h0003_0001, 2'b00);
    run_walk("l0_rsvd",  1'b1, 32'h0040_1234, 22'h00080, 32'h0002_0401, 2'b00, 32'h0003_0005, 2'b00);

    flush_test();
    reset_test();
    run_walk("post_rst", 1'b1, 32'h0040_1234, 22'h00080, 32'h0002_0401, 2'b00, 32'h1234_50CF, 2'b00);

    for (int n = 0; n < 40; n++) begin
      md  = ($urandom_range(0, 4) != 0);
      va  = $urandom;
      ppn = 22'($urandom);
      p1  = rand_pte();
      p0  = rand_pte();
      r1  = rand_resp();
      r0  = rand_resp();
      run_walk("rand", md, va, ppn, p1, r1, p0, r0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/itlb_ptw.md
ITLB_PTW -- requirements
Module: Itlb_Ptw

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH 32, virtual/physical address width; DATA_WIDTH 32, PTE width; PAGE_OFFSET_WIDTH 12, page offset bits; VPN_LEN 10, bits per VPN level; PPN_LEN 22, PTE PPN field width.
REQ-002 SHALL have ports, one clock, reset asynchronous active-low:
CLK  in  1  clock, all state on rising edge
RST  in  1  asynchronous active-low reset
REQ_VALID  in  1  walk request pulse from I-TLB (its ADDR_TO_AXIM_VALID)
REQ_VADDR  in  32  virtual address to translate
FLUSH  in  1  TLB flush; cancels response of walk in flight
SATP_MODE  in  1  0 bare, 1 Sv32
SATP_PPN  in  22  root page-table PPN
RESP_VALID  out  1  one-cycle response pulse (I-TLB DATA_FROM_AXIM_VALID)
RESP_DATA  out  32  leaf PTE; PPN in [31:10], flags in [9:0]
FAULT  out  1  qualifies RESP_VALID as fault
FAULT_TYPE  out  2  01 page fault, 10 access fault
BUSY  out  1  walk in progress
M_ARVALID / M_ARREADY  out/in  1  AXI read address handshake
M_ARADDR  out  32  PTE physical address
M_RVALID / M_RREADY  in/out  1  AXI read data handshake
M_RDATA  in  32  PTE read data
M_RRESP  in  2  read response, nonzero = error

Function
REQ-003 SHALL implement registered FSM IDLE, AR1, R1, AR0, R0, RESP; BUSY=1 in every state except IDLE.
REQ-004 IDLE + REQ_VALID: latch REQ_VADDR; SATP_MODE=0 -> RESP, else AR1; REQ_VALID outside IDLE SHALL be ignored.
REQ-005 Bare mode: RESP_DATA={2'b00, vaddr[31:12], 10'h0CF}, RESP_VALID exactly one cycle after request cycle, no AXI traffic.
REQ-006 AR1: M_ARADDR = lower 32 bits of {SATP_PPN, vaddr[31:22], 2'b00}; AR0: lower 32 bits of {pte1[31:10], vaddr[21:12], 2'b00}.
REQ-007 M_ARVALID and M_ARADDR SHALL hold stable until M_ARREADY; handshake cycle moves ARn->Rn.
REQ-008 M_RREADY SHALL be 1 in IDLE, R1, R0, else 0; beats accepted in IDLE discarded.
REQ-009 Rn beat with M_RRESP!=0 -> access fault (FAULT_TYPE 10).
REQ-010 PTE with V=0, or R=0 & W=1 -> page fault (01).
REQ-011 R1 non-leaf (R=X=0) -> AR0; R0 non-leaf -> page fault.
REQ-012 Leaf (R|X) in R0 -> RESP with RESP_DATA=PTE unchanged.
REQ-013 Leaf in R1: handled per REQ-019/020.
REQ-014 RESP state drives RESP_VALID=1 one cycle, then IDLE; on fault RESP_DATA=0, FAULT=1; else FAULT=0, FAULT_TYPE=00.
REQ-015 FLUSH in any non-IDLE state: set cancel flag; outstanding AR/R completes, no further level issued, return to IDLE without RESP_VALID.
REQ-016 Outputs SHALL be registered; RESP_DATA/FAULT/FAULT_TYPE hold last value while RESP_VALID=0.

Reset
REQ-017 RST low SHALL asynchronously force IDLE, clear cancel flag, latched vaddr, RESP_VALID, FAULT, FAULT_TYPE, RESP_DATA, M_ARVALID, M_ARADDR, BUSY to 0; M_RREADY=1.
REQ-018 Reset mid-walk SHALL abandon the transaction; stray beat after reset drained per REQ-008.

Configuration
REQ-019 Macro ITLB_PTW_SUPERPAGE_EN defined: level-1 leaf with pte[19:10]==0 -> RESP with RESP_DATA={pte[31:20], vaddr[21:12], pte[9:0]}; pte[19:10]!=0 -> page fault.
REQ-020 Macro undefined: any level-1 leaf -> page fault (01), no AR0 issued.

Verification
REQ-021 SATP_MODE=0, REQ_VADDR=0x8000_1ABC -> next cycle RESP_VALID=1, RESP_DATA=0x2000_04CF, FAULT=0, no M_ARVALID.
REQ-022 SATP_MODE=1, SATP_PPN=0x00080, vaddr 0x0040_1234, L1 data 0x0002_0401, L0 data 0x1234_50CF -> ARADDR 0x0008_0004 then 0x0008_1004, RESP_DATA=0x1234_50CF, FAULT=0.
REQ-023 Same walk, L1 M_RRESP=2'b10 -> no AR0, RESP_VALID with FAULT=1, FAULT_TYPE=10, RESP_DATA=0.
REQ-024 L1 data 0x2000_000F: with ITLB_PTW_SUPERPAGE_EN RESP_DATA=0x2000_040F; without, FAULT=1, FAULT_TYPE=01.
REQ-025 FLUSH pulse in R1, M_ARREADY held low 5 cycles in AR1 of prior test -> L1 beat consumed, no AR0, no RESP_VALID, BUSY=0 cycle after beat.
REQ-026 RST low during AR0 -> M_ARVALID=0, BUSY=0 immediately; later M_RVALID accepted (M_RREADY=1) without RESP_VALID.
